decode_stage_hs: RTL and testbench

DECODE_STAGE_HS -- requirements
Module: decode_stage_hs

---
 rtl/vp_decode_pkg.sv | 76 +++++++
 rtl/dec_scoreboard.sv | 42 ++++
 rtl/decode_stage_hs.sv | 135 +++++++++++++
 tb/tb_decode_stage_hs.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_decode_pkg.sv
// Shared decode definitions: instruction field positions, opcode map,
// control bundle layout and the opcode-to-control decode function.
package vp_decode_pkg;

    localparam int INSTR_W  = 21;
    localparam int TYPE_BIT = 20;
    localparam int OPC_HI   = 19;
    localparam int OPC_LO   = 16;
    localparam int DEST_HI  = 15;
    localparam int DEST_LO  = 12;
    localparam int SRC1_HI  = 11;
    localparam int SRC1_LO  = 8;
    localparam int SRC2_HI  = 7;
    localparam int SRC2_LO  = 4;
    localparam int IMM_HI   = 7;
    localparam int IMM_LO   = 0;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_RR1   = 4'h1,
        OP_RR2   = 4'h2,
        OP_RR3   = 4'h3,
        OP_RR4   = 4'h4,
        OP_RR5   = 4'h5,
        OP_RR6   = 4'h6,
        OP_RR7   = 4'h7,
        OP_IMM8  = 4'h8,
        OP_IMM9  = 4'h9,
        OP_LOAD  = 4'hA,
        OP_STORE = 4'hB,
        OP_ILLC  = 4'hC,
        OP_ILLD  = 4'hD,
        OP_ILLE  = 4'hE,
        OP_ILLF  = 4'hF
    } opcode_e;

    typedef struct packed {
        logic [4:0] alu_op;
        logic       mem_rd;
        logic       mem_wr;
        logic       wb_en;
        logic       uses_imm;
    } ctrl_t;

    // Opcodes 0xC-0xF have no defined behaviour and travel as bubbles with a flag.
    function automatic logic is_illegal_op(input logic [3:0] opc);
        return (opc >= 4'hC);
    endfunction

    // Map an opcode onto its exec/mem/wb control bundle; illegal and NOP give all zero.
    function automatic ctrl_t decode_ctrl(input logic [3:0] opc);
        ctrl_t c;
        c = '0;
        case (opc)
            OP_RR1, OP_RR2, OP_RR3, OP_RR4, OP_RR5, OP_RR6, OP_RR7: begin
                c.alu_op = {1'b0, opc};
                c.wb_en  = 1'b1;
            end
            OP_IMM8, OP_IMM9: begin
                c.alu_op   = {1'b0, opc};
                c.wb_en    = 1'b1;
                c.uses_imm = 1'b1;
            end
            OP_LOAD: begin
                c.mem_rd = 1'b1;
                c.wb_en  = 1'b1;
            end
            OP_STORE: begin
                c.mem_wr = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dec_scoreboard.sv
// Pending-write scoreboard: one bit per register per bank (scalar, vector).
// A bit is set when a writer leaves decode and cleared when it retires.
module dec_scoreboard
    import vp_decode_pkg::*;
#(
    parameter  int NREGS = 16,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en,
    input  logic          set_type,
    input  logic [RW-1:0] set_addr,
    input  logic          clr_en,
    input  logic          clr_type,
    input  logic [RW-1:0] clr_addr,
    input  logic          lu_type,
    input  logic [RW-1:0] lu_addr1,
    input  logic [RW-1:0] lu_addr2,
    input  logic [RW-1:0] lu_addr3,
    output logic          lu_hit1,
    output logic          lu_hit2,
    output logic          lu_hit3
);

    logic [1:0][NREGS-1:0] pending;

    // Update pending bits; the set is written last so it overrides a same-bit clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (clr_en) pending[clr_type][clr_addr] <= 1'b0;
            if (set_en) pending[set_type][set_addr] <= 1'b1;
        end
    end

    assign lu_hit1 = pending[lu_type][lu_addr1];
    assign lu_hit2 = pending[lu_type][lu_addr2];
    assign lu_hit3 = pending[lu_type][lu_addr3];

endmodule

// File: rtl/decode_stage_hs.sv
// Decode stage with valid/ready handshake: reads operands from the scalar or
// vector bank, decodes control, stalls on RAW/WAW hazards and holds one
// decoded instruction in a registered output stage.
module decode_stage_hs
    import vp_decode_pkg::*;
#(
    parameter  int ELEM_W = 8,
    parameter  int LANES  = 24,
    parameter  int NREGS  = 16,
    localparam int VW     = LANES * ELEM_W,
    localparam int RW     = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic [RW-1:0]      rf_raddr1,
    output logic [RW-1:0]      rf_raddr2,
    input  logic [ELEM_W-1:0]  rf_s_rdata1,
    input  logic [ELEM_W-1:0]  rf_s_rdata2,
    input  logic [VW-1:0]      rf_v_rdata1,
    input  logic [VW-1:0]      rf_v_rdata2,
    input  logic               wb_valid,
    input  logic               wb_type,
    input  logic [RW-1:0]      wb_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output ctrl_t              out_ctrl,
    output logic [ELEM_W-1:0]  out_imm,
    output logic [ELEM_W-1:0]  out_r1e,
    output logic [ELEM_W-1:0]  out_r2e,
    output logic [VW-1:0]      out_r1v,
    output logic [VW-1:0]      out_r2v,
    output logic [RW-1:0]      out_dest,
    output logic               out_dest_type,
    output logic               out_illegal
);

    logic          in_type;
    logic [3:0]    in_opc;
    logic [RW-1:0] in_dest;
    logic [RW-1:0] in_src1;
    logic [RW-1:0] in_src2;
    ctrl_t         in_ctrl;
    logic          in_ill;
    logic          active;
    logic          pend1, pend2, pend3;
    logic          held1, held2, held3;
    logic          hazard;
    logic          accept;
    logic          xfer;

    assign in_type = in_instr[TYPE_BIT];
    assign in_opc  = in_instr[OPC_HI:OPC_LO];
    assign in_dest = in_instr[DEST_HI:DEST_LO];
    assign in_src1 = in_instr[SRC1_HI:SRC1_LO];
    assign in_src2 = in_instr[SRC2_HI:SRC2_LO];
    assign in_ctrl = decode_ctrl(in_opc);
    assign in_ill  = is_illegal_op(in_opc);

    assign rf_raddr1 = in_src1;
    assign rf_raddr2 = in_src2;

    dec_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (xfer && out_ctrl.wb_en),
        .set_type (out_dest_type),
        .set_addr (out_dest),
        .clr_en   (wb_valid),
        .clr_type (wb_type),
        .clr_addr (wb_addr),
        .lu_type  (in_type),
        .lu_addr1 (in_src1),
        .lu_addr2 (in_src2),
        .lu_addr3 (in_dest),
        .lu_hit1  (pend1),
        .lu_hit2  (pend2),
        .lu_hit3  (pend3)
    );

    // A held writer has not reached the scoreboard yet, so match it directly.
    assign held1 = out_valid && out_ctrl.wb_en && (out_dest_type == in_type) && (out_dest == in_src1);
    assign held2 = out_valid && out_ctrl.wb_en && (out_dest_type == in_type) && (out_dest == in_src2);
    assign held3 = out_valid && out_ctrl.wb_en && (out_dest_type == in_type) && (out_dest == in_dest);

    // NOP and illegal opcodes read nothing, so they can never stall.
    assign active = in_valid && (in_opc != OP_NOP) && !in_ill;
    assign hazard = active && ((pend1 || held1) ||
                               (!in_ctrl.uses_imm && (pend2 || held2)) ||
                               (in_ctrl.wb_en && (pend3 || held3)));

    assign in_ready = rst_n && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    // Output stage: load on accept, otherwise drain on transfer or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_ctrl      <= '0;
            out_imm       <= '0;
            out_r1e       <= '0;
            out_r2e       <= '0;
            out_r1v       <= '0;
            out_r2v       <= '0;
            out_dest      <= '0;
            out_dest_type <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_ctrl      <= in_ctrl;
            out_imm       <= ELEM_W'(in_instr[IMM_HI:IMM_LO]);
            out_dest      <= in_dest;
            out_dest_type <= in_type;
            out_illegal   <= in_ill;
            if (in_type) begin
                out_r1e <= '0;
                out_r2e <= '0;
                out_r1v <= rf_v_rdata1;
                out_r2v <= rf_v_rdata2;
            end else begin
                out_r1e <= rf_s_rdata1;
                out_r2e <= rf_s_rdata2;
                out_r1v <= '0;
                out_r2v <= '0;
            end
        end else if (xfer || flush) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage_hs.sv
// Self-checking bench for decode_stage_hs: accepted instructions push their
// expected decoded bundle into a queue, which is compared while held and
// popped on transfer (or discarded on flush).
module tb_decode_stage_hs;
    import vp_decode_pkg::*;

    localparam int ELEM_W = 8;
    localparam int LANES  = 24;
    localparam int NREGS  = 16;
    localparam int VW     = LANES * ELEM_W;
    localparam int RW     = 4;

    typedef struct packed {
        logic [8:0]    ctrl;
        logic [7:0]    imm;
        logic [7:0]    r1e;
        logic [7:0]    r2e;
        logic [VW-1:0] r1v;
        logic [VW-1:0] r2v;
        logic [3:0]    dest;
        logic          dtype;
        logic          ill;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [20:0]       in_instr;
    logic              flush;
    logic [RW-1:0]     rf_raddr1, rf_raddr2;
    logic [ELEM_W-1:0] rf_s_rdata1, rf_s_rdata2;
    logic [VW-1:0]     rf_v_rdata1, rf_v_rdata2;
    logic              wb_valid, wb_type;
    logic [RW-1:0]     wb_addr;
    logic              out_valid, out_ready;
    ctrl_t             out_ctrl;
    logic [ELEM_W-1:0] out_imm, out_r1e, out_r2e;
    logic [VW-1:0]     out_r1v, out_r2v;
    logic [RW-1:0]     out_dest;
    logic              out_dest_type, out_illegal;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    decode_stage_hs #(.ELEM_W(ELEM_W), .LANES(LANES), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .flush(flush),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_s_rdata1(rf_s_rdata1), .rf_s_rdata2(rf_s_rdata2),
        .rf_v_rdata1(rf_v_rdata1), .rf_v_rdata2(rf_v_rdata2),
        .wb_valid(wb_valid), .wb_type(wb_type), .wb_addr(wb_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_imm(out_imm), .out_r1e(out_r1e), .out_r2e(out_r2e),
        .out_r1v(out_r1v), .out_r2v(out_r2v),
        .out_dest(out_dest), .out_dest_type(out_dest_type), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: contents are a fixed function of the address.
    function automatic logic [7:0] sdat(input logic [3:0] a);
        return {2'b00, a, 2'b01};
    endfunction

    function automatic logic [VW-1:0] vdat(input logic [3:0] a);
        logic [VW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*8 +: 8] = {a, 4'hA};
        return v;
    endfunction

    assign rf_s_rdata1 = sdat(rf_raddr1);
    assign rf_s_rdata2 = sdat(rf_raddr2);
    assign rf_v_rdata1 = vdat(rf_raddr1);
    assign rf_v_rdata2 = vdat(rf_raddr2);

    function automatic logic [20:0] mk(input logic t, input logic [3:0] op, input logic [3:0] d,
                                       input logic [3:0] s1, input logic [3:0] s2);
        return {t, op, d, s1, s2, 4'h0};
    endfunction

    // Reference decode written from the opcode table.
    function automatic exp_t model(input logic [20:0] i);
        exp_t e;
        logic [3:0] op;
        logic t;
        op = i[19:16];
        t  = i[20];
        e  = '0;
        e.ctrl[8:4] = (op >= 4'h1 && op <= 4'h9) ? {1'b0, op} : 5'h00;
        e.ctrl[3]   = (op == 4'hA);
        e.ctrl[2]   = (op == 4'hB);
        e.ctrl[1]   = (op >= 4'h1 && op <= 4'hA);
        e.ctrl[0]   = (op == 4'h8 || op == 4'h9);
        e.imm   = i[7:0];
        e.r1e   = t ? 8'h00 : sdat(i[11:8]);
        e.r2e   = t ? 8'h00 : sdat(i[7:4]);
        e.r1v   = t ? vdat(i[11:8]) : '0;
        e.r2v   = t ? vdat(i[7:4]) : '0;
        e.dest  = i[15:12];
        e.dtype = t;
        e.ill   = (op >= 4'hC);
        return e;
    endfunction

    function automatic exp_t observed();
        return {out_ctrl, out_imm, out_r1e, out_r2e, out_r1v, out_r2v, out_dest, out_dest_type, out_illegal};
    endfunction

    function automatic exp_t front();
        if (exp_q.size() == 0) return 'x;
        return exp_q[0];
    endfunction

    // Advance one clock, updating the scoreboard from the handshake just before the edge.
    task automatic step();
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (out_valid && flush) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_instr));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic retire(input logic t, input logic [3:0] a);
        wb_valid = 1'b1;
        wb_type  = t;
        wb_addr  = a;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_instr = mk(1'b0, 4'h1, 4'h3, 4'h1, 4'h2);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (observed() !== exp_t'('0)) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", observed());
        end
    endtask

    task automatic test_scalar_alu();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL deassert_accept: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL alu_out_valid: got %b expected 1", out_valid);
        end
        vectors++;
        if (observed() !== front()) begin
            miscompares++;
            $display("[TB] FAIL alu_bundle: got %h expected %h", observed(), front());
        end
        vectors++;
        if (out_r1e !== 8'h05 || out_r1v !== '0 || out_ctrl.alu_op !== 5'h01) begin
            miscompares++;
            $display("[TB] FAIL alu_fields: got r1e=%h alu=%h expected r1e=05 alu=01 r1v=0", out_r1e, out_ctrl.alu_op);
        end
    endtask

    task automatic test_back_to_back();
        in_instr  = mk(1'b0, 4'h2, 4'h4, 4'h3, 4'h5);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL raw_stall_%0d: got %b expected 0", c, in_ready);
            end
            step();
        end
        wb_valid = 1'b1;
        wb_type  = 1'b0;
        wb_addr  = 4'h3;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wb_same_cycle: got %b expected 0", in_ready);
        end
        step();
        wb_valid = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wb_next_cycle: got %b expected 1", in_ready);
        end
        step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || observed() !== front()) begin
            miscompares++;
            $display("[TB] FAIL reader_bundle: got v=%b %h expected %h", out_valid, observed(), front());
        end
    endtask

    task automatic test_stall();
        in_instr = {1'b0, 4'h8, 4'h5, 4'h6, 8'h67};
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL stall_hs_%0d: got ready=%b valid=%b expected ready=0 valid=1", c, in_ready, out_valid);
            end
            vectors++;
            if (observed() !== front()) begin
                miscompares++;
                $display("[TB] FAIL stall_hold_%0d: got %h expected %h", c, observed(), front());
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL release_ready: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || observed() !== front()) begin
            miscompares++;
            $display("[TB] FAIL imm_bundle: got v=%b %h expected %h", out_valid, observed(), front());
        end
        vectors++;
        if (out_ctrl.uses_imm !== 1'b1 || out_imm !== 8'h67) begin
            miscompares++;
            $display("[TB] FAIL imm_fields: got uses_imm=%b imm=%h expected 1 67", out_ctrl.uses_imm, out_imm);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL imm_drain: got %b expected 0", out_valid);
        end
    endtask

    // r4 and r5 (scalar) are pending here and nothing is held.
    task automatic test_hazard_table();
        logic [20:0] instrs [10];
        logic        valids [10];
        logic        readys [10];
        instrs[0] = mk(1'b1, 4'h1, 4'h1, 4'h5, 4'h0); valids[0] = 1'b1; readys[0] = 1'b1;
        instrs[1] = mk(1'b0, 4'h8, 4'h1, 4'h0, 4'h5); valids[1] = 1'b1; readys[1] = 1'b1;
        instrs[2] = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'h5); valids[2] = 1'b1; readys[2] = 1'b0;
        instrs[3] = mk(1'b0, 4'h1, 4'h5, 4'h0, 4'h0); valids[3] = 1'b1; readys[3] = 1'b0;
        instrs[4] = mk(1'b0, 4'h1, 4'h1, 4'h5, 4'h0); valids[4] = 1'b1; readys[4] = 1'b0;
        instrs[5] = mk(1'b0, 4'hB, 4'h5, 4'h0, 4'h0); valids[5] = 1'b1; readys[5] = 1'b1;
        instrs[6] = mk(1'b0, 4'hB, 4'h1, 4'h0, 4'h4); valids[6] = 1'b1; readys[6] = 1'b0;
        instrs[7] = mk(1'b0, 4'h0, 4'h5, 4'h5, 4'h5); valids[7] = 1'b1; readys[7] = 1'b1;
        instrs[8] = mk(1'b0, 4'hD, 4'h5, 4'h5, 4'h5); valids[8] = 1'b1; readys[8] = 1'b1;
        instrs[9] = mk(1'b0, 4'h1, 4'h1, 4'h5, 4'h0); valids[9] = 1'b0; readys[9] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_instr = instrs[k];
            in_valid = valids[k];
            #1;
            vectors++;
            if (in_ready !== readys[k]) begin
                miscompares++;
                $display("[TB] FAIL hazard_%0d: got %b expected %b", k, in_ready, readys[k]);
            end
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        in_instr = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'h0);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_blocks: got %b expected 0", in_ready);
        end
        flush = 1'b0;
        #1;
        retire(1'b0, 4'h4);
        retire(1'b0, 4'h5);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_instr  = mk(1'b1, 4'hA, 4'h7, 4'h2, 4'h9);
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || observed() !== front()) begin
            miscompares++;
            $display("[TB] FAIL vload_bundle: got v=%b %h expected %h", out_valid, observed(), front());
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_drop: got %b expected 0", out_valid);
        end
        in_instr = mk(1'b1, 4'h1, 4'h8, 4'h7, 4'h7);
        in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush_no_pending: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || observed() !== front()) begin
            miscompares++;
            $display("[TB] FAIL vreader_bundle: got v=%b %h expected %h", out_valid, observed(), front());
        end
        out_ready = 1'b1;
        step();
        retire(1'b1, 4'h8);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL queue_drained: got %0d entries expected 0", exp_q.size());
        end
    endtask

    task automatic test_illegal_and_reset();
        out_ready = 1'b0;
        in_instr  = mk(1'b0, 4'hE, 4'h9, 4'h1, 4'h2);
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_illegal !== 1'b1 || out_ctrl !== ctrl_t'('0) || observed() !== front()) begin
            miscompares++;
            $display("[TB] FAIL illegal_bundle: got %h expected %h", observed(), front());
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_instr  = mk(1'b0, 4'h1, 4'h9, 4'h0, 4'h0);
        in_valid  = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL illegal_no_pending: got %b expected 1", in_ready);
        end
        step();
        in_instr = mk(1'b0, 4'h2, 4'hA, 4'h9, 4'h0);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL held_raw: got %b expected 0", in_ready);
        end
        step();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || observed() !== exp_t'('0)) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got v=%b r=%b %h expected all 0", out_valid, in_ready, observed());
        end
        exp_q.delete();
        step();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL post_reset_accept: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || observed() !== front()) begin
            miscompares++;
            $display("[TB] FAIL post_reset_bundle: got v=%b %h expected %h", out_valid, observed(), front());
        end
        out_ready = 1'b1;
        step();
        retire(1'b0, 4'hA);
    endtask

    // Test sequence; each test leaves the stage idle or in the state the next one expects.
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        flush     = 1'b0;
        wb_valid  = 1'b0;
        wb_type   = 1'b0;
        wb_addr   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_scalar_alu();
        test_back_to_back();
        test_stall();
        test_hazard_table();
        test_flush();
        test_illegal_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
